ps2_scan_rx: RTL and testbench
==============================

PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 FILTER_LEN, 8, consecutive equal synchronized samples required before the filtered PS/2 clock or data changes level.
REQ-002 TIMEOUT_CYCLES, 3000, idle clk cycles between filtered falling edges before an in-progress frame is abandoned.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 strobe  output  1  one-cycle pulse when a valid scancode is on code; feeds the scancode converter's strobe_in.
REQ-008 code  output  8  last valid scancode received; feeds the scancode converter's code_in.
REQ-009 frame_err  output  1  one-cycle pulse on a rejected frame (bad stop, bad parity, timeout).
REQ-010 busy  output  1  high while the FSM is in any state other than IDLE.

Function
REQ-011 ps2_clk and ps2_data each pass through a 2-flop synchronizer, then a FILTER_LEN-deep stability filter.
REQ-012 Filtered output changes only after FILTER_LEN consecutive identical synchronized samples; shorter pulses are ignored.
REQ-013 A falling edge is a filtered-clock 1->0 transition, detected as a single-cycle event; data is sampled from filtered data in that cycle.
REQ-014 FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: falling edge with data=0 (start bit) -> DATA, bit counter=0, shift register cleared; falling edge with data=1 -> stay IDLE, no pulse.
REQ-016 DATA: each falling edge shifts data in LSB first; after 8th bit -> PARITY.
REQ-017 PARITY: falling edge captures parity bit -> STOP.
REQ-018 STOP: falling edge ends the frame -> IDLE; frame valid if stop bit=1 and parity check (REQ-030) passes.
REQ-019 Valid frame: the cycle after the stop-bit falling edge, code loads the shift register and strobe=1 for exactly one cycle.
REQ-020 Invalid frame: code unchanged, strobe stays 0, frame_err=1 for exactly one cycle, same timing as REQ-019.
REQ-021 code holds its value until the next valid frame.
REQ-022 Timeout counter clears on every falling edge and in IDLE; counts otherwise; saturates at TIMEOUT_CYCLES.
REQ-023 Counter reaching TIMEOUT_CYCLES outside IDLE -> IDLE next cycle, frame_err pulse, no strobe; partial data discarded.
REQ-024 Timeout and a falling edge in the same cycle: the edge is processed and the counter clears.
REQ-025 strobe and frame_err are never high in the same cycle; minimum spacing between strobes is one full frame.

Reset
REQ-026 reset=0 asynchronously forces FSM=IDLE, counters=0, shift register=0, code=8'h00, strobe=0, frame_err=0, busy=0.
REQ-027 Synchronizer and filter flops reset to 1 (idle line level), so release of reset never produces a false falling edge.
REQ-028 Reset asserted mid-frame discards the frame; no strobe or frame_err is emitted for it.
REQ-029 After reset deasserts, the first frame is accepted only from a clean start bit.

Configuration
REQ-030 Macro PS2_PARITY_CHECK_EN defined: odd parity is required (data plus parity bit has an odd count of ones); mismatch rejects the frame per REQ-020.
REQ-031 Macro undefined: the parity bit is sampled and ignored; only the stop bit validates the frame; port list unchanged.

Verification
REQ-032 Frame 0x1C, parity 0, stop 1 -> exactly one strobe, code=0x1C, frame_err stays 0, busy low afterwards.
REQ-033 Frames 0x1C, 0xF0, 0x1C back-to-back -> three strobes with codes 0x1C, 0xF0, 0x1C in order.
REQ-034 Frame 0x1C with parity 1 -> macro defined: frame_err pulse, no strobe, code unchanged; macro undefined: strobe with code=0x1C.
REQ-035 Frame 0x32 with stop bit 0 -> frame_err pulse, no strobe.
REQ-036 Four bits of a frame, then idle for more than TIMEOUT_CYCLES -> frame_err pulse, FSM in IDLE; following frame 0x5A -> strobe, code=0x5A.
REQ-037 ps2_clk glitch low for FILTER_LEN-2 cycles while idle -> no state change; reset=0 mid-frame then frame 0x12 -> only one strobe, code=0x12.

Source files
------------

// File: rtl/ps2_scan_rx_if.sv
// PS/2 receiver bus: raw PS/2 lines in, scancode strobe/code and status out.
interface ps2_scan_rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       strobe;
   logic [7:0] code;
   logic       frame_err;
   logic       busy;

   modport master (
      output ps2_clk, ps2_data,
      input  strobe, code, frame_err, busy
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output strobe, code, frame_err, busy
   );
endinterface

// File: rtl/ps2_scan_rx.sv
// PS/2 scancode receiver: synchronize, deglitch, frame decode with timeout.
// Define PS2_PARITY_CHECK_EN to reject frames that fail the odd-parity check.
module ps2_scan_rx #(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 3000
) (
   input  logic          clk,
   input  logic          reset,
   ps2_scan_rx_if.slave  bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;
   localparam logic [1:0] STOP   = 2'd3;

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

   // Bit 0 carries ps2_clk, bit 1 carries ps2_data.
   logic [1:0]         s1_q, s2_q, filt_q, filt_d;
   logic [1:0][FW-1:0] fcnt_q, fcnt_d;
   logic               fclk_d1_q;
   logic               fall, sdata;

   logic [1:0]    state_q, state_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_ok_q, par_ok_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    code_q, code_d;
   logic          strobe_q, strobe_d;
   logic          ferr_q, ferr_d;

   always_comb begin
      for (int unsigned i = 0; i < 2; i++) begin
         filt_d[i] = filt_q[i];
         fcnt_d[i] = '0;
         if (s2_q[i] != filt_q[i]) begin
            if (fcnt_q[i] == FLT_MAX) filt_d[i] = s2_q[i];
            else                      fcnt_d[i] = fcnt_q[i] + 1'b1;
         end
      end
   end

   assign fall  = fclk_d1_q & ~filt_q[0];
   assign sdata = filt_q[1];

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      par_ok_d = par_ok_q;
      code_d   = code_q;
      strobe_d = 1'b0;
      ferr_d   = 1'b0;

      if (state_q == IDLE || fall) tmo_d = '0;
      else if (tmo_q != TMO_MAX)   tmo_d = tmo_q + 1'b1;
      else                         tmo_d = tmo_q;

      case (state_q)
         IDLE: if (fall && !sdata) begin
            state_d  = DATA;
            bitcnt_d = '0;
            shift_d  = '0;
         end
         DATA: if (fall) begin
            shift_d  = {sdata, shift_q[7:1]};
            bitcnt_d = bitcnt_q + 1'b1;
            if (bitcnt_q == 3'd7) state_d = PARITY;
         end
         PARITY: if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
            par_ok_d = ^{shift_q, sdata};
`else
            par_ok_d = 1'b1;
`endif
            state_d  = STOP;
         end
         default: if (fall) begin
            state_d = IDLE;
            if (sdata && par_ok_q) begin
               strobe_d = 1'b1;
               code_d   = shift_q;
            end else begin
               ferr_d = 1'b1;
            end
         end
      endcase

      // A falling edge in the timeout cycle wins; the edge is processed above.
      if (state_q != IDLE && !fall && tmo_q == TMO_MAX) begin
         state_d = IDLE;
         shift_d = '0;
         ferr_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q      <= '1;
         s2_q      <= '1;
         filt_q    <= '1;
         fcnt_q    <= '0;
         fclk_d1_q <= 1'b1;
         state_q   <= IDLE;
         bitcnt_q  <= '0;
         shift_q   <= '0;
         par_ok_q  <= 1'b0;
         tmo_q     <= '0;
         code_q    <= '0;
         strobe_q  <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         s1_q      <= {bus.ps2_data, bus.ps2_clk};
         s2_q      <= s1_q;
         filt_q    <= filt_d;
         fcnt_q    <= fcnt_d;
         fclk_d1_q <= filt_q[0];
         state_q   <= state_d;
         bitcnt_q  <= bitcnt_d;
         shift_q   <= shift_d;
         par_ok_q  <= par_ok_d;
         tmo_q     <= tmo_d;
         code_q    <= code_d;
         strobe_q  <= strobe_d;
         ferr_q    <= ferr_d;
      end
   end

   assign bus.strobe    = strobe_q;
   assign bus.code      = code_q;
   assign bus.frame_err = ferr_q;
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: frames, parity/stop errors, timeout, glitch, reset.
module tb_ps2_scan_rx;
   localparam int HALF = 20;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   strobe_cnt = 0;
   int   err_cnt = 0;
   int   both_cnt = 0;
   int   s0, e0;

   ps2_scan_rx_if ps2_bus ();

   ps2_scan_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(3000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ps2_bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ps2_bus.strobe)    strobe_cnt++;
      if (ps2_bus.frame_err) err_cnt++;
      if (ps2_bus.strobe && ps2_bus.frame_err) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ps2_bit(input logic b);
      ps2_bus.ps2_data = b;
      cycles(HALF);
      ps2_bus.ps2_clk = 1'b0;
      cycles(HALF);
      ps2_bus.ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit(par);
      ps2_bit(stp);
      ps2_bus.ps2_data = 1'b1;
   endtask

   initial begin
      ps2_bus.ps2_clk  = 1'b1;
      ps2_bus.ps2_data = 1'b1;
      cycles(5);
      @(negedge clk);
      check("rst_code",   {24'h0, ps2_bus.code}, 32'h00);
      check("rst_strobe", {31'h0, ps2_bus.strobe}, 32'h0);
      check("rst_ferr",   {31'h0, ps2_bus.frame_err}, 32'h0);
      check("rst_busy",   {31'h0, ps2_bus.busy}, 32'h0);
      reset = 1'b1;
      cycles(30);
      check("rel_no_pulse", strobe_cnt + err_cnt, 0);

      // Single valid frame, with a busy probe mid-frame
      s0 = strobe_cnt; e0 = err_cnt;
      ps2_bit(1'b0);
      ps2_bit(1'b0);
      check("busy_mid", {31'h0, ps2_bus.busy}, 32'h1);
      for (int i = 1; i < 8; i++) ps2_bit(i == 2 || i == 3 || i == 4);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bus.ps2_data = 1'b1;
      cycles(10);
      check("f1c_strobe", strobe_cnt - s0, 1);
      check("f1c_code",   {24'h0, ps2_bus.code}, 32'h1C);
      check("f1c_ferr",   err_cnt - e0, 0);
      check("f1c_busy",   {31'h0, ps2_bus.busy}, 32'h0);

      // Back-to-back 1C F0 1C
      s0 = strobe_cnt; e0 = err_cnt;
      send_frame(8'h1C, 1'b0, 1'b1);
      check("b2b_code0", {24'h0, ps2_bus.code}, 32'h1C);
      send_frame(8'hF0, 1'b1, 1'b1);
      check("b2b_code1", {24'h0, ps2_bus.code}, 32'hF0);
      send_frame(8'h1C, 1'b0, 1'b1);
      check("b2b_code2", {24'h0, ps2_bus.code}, 32'h1C);
      check("b2b_strobes", strobe_cnt - s0, 3);
      check("b2b_ferr", err_cnt - e0, 0);

      // Load F0 so an unchanged code is distinguishable, then bad parity 1C
      send_frame(8'hF0, 1'b1, 1'b1);
      s0 = strobe_cnt; e0 = err_cnt;
      send_frame(8'h1C, 1'b1, 1'b1);
      cycles(10);
`ifdef PS2_PARITY_CHECK_EN
      check("par_ferr",   err_cnt - e0, 1);
      check("par_strobe", strobe_cnt - s0, 0);
      check("par_code",   {24'h0, ps2_bus.code}, 32'hF0);
`else
      check("par_ferr",   err_cnt - e0, 0);
      check("par_strobe", strobe_cnt - s0, 1);
      check("par_code",   {24'h0, ps2_bus.code}, 32'h1C);
`endif

      // Bad stop bit
      s0 = strobe_cnt; e0 = err_cnt;
      send_frame(8'h32, 1'b0, 1'b0);
      cycles(10);
      check("stop_ferr",   err_cnt - e0, 1);
      check("stop_strobe", strobe_cnt - s0, 0);

      // Partial frame then timeout
      s0 = strobe_cnt; e0 = err_cnt;
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bus.ps2_data = 1'b1;
      check("tmo_busy_before", {31'h0, ps2_bus.busy}, 32'h1);
      cycles(2900);
      check("tmo_not_early", err_cnt - e0, 0);
      cycles(300);
      check("tmo_ferr",   err_cnt - e0, 1);
      check("tmo_strobe", strobe_cnt - s0, 0);
      check("tmo_busy",   {31'h0, ps2_bus.busy}, 32'h0);
      send_frame(8'h5A, 1'b1, 1'b1);
      cycles(10);
      check("tmo_next_code",   {24'h0, ps2_bus.code}, 32'h5A);
      check("tmo_next_strobe", strobe_cnt - s0, 1);

      // Short clock glitch with data low must not start a frame
      s0 = strobe_cnt; e0 = err_cnt;
      ps2_bus.ps2_data = 1'b0;
      cycles(12);
      ps2_bus.ps2_clk = 1'b0;
      cycles(6);
      ps2_bus.ps2_clk = 1'b1;
      cycles(20);
      check("glitch_busy", {31'h0, ps2_bus.busy}, 32'h0);
      ps2_bus.ps2_data = 1'b1;
      cycles(20);
      check("glitch_pulses", (strobe_cnt - s0) + (err_cnt - e0), 0);

      // Reset mid-frame, then a clean frame
      s0 = strobe_cnt; e0 = err_cnt;
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b1);
      ps2_bus.ps2_data = 1'b1;
      check("rstmid_busy_before", {31'h0, ps2_bus.busy}, 32'h1);
      #2 reset = 1'b0;
      cycles(5);
      check("rstmid_code", {24'h0, ps2_bus.code}, 32'h00);
      reset = 1'b1;
      cycles(3200);
      check("rstmid_busy",   {31'h0, ps2_bus.busy}, 32'h0);
      check("rstmid_pulses", (strobe_cnt - s0) + (err_cnt - e0), 0);
      send_frame(8'h12, 1'b1, 1'b1);
      cycles(10);
      check("rstmid_strobe", strobe_cnt - s0, 1);
      check("rstmid_code12", {24'h0, ps2_bus.code}, 32'h12);
      check("rstmid_ferr",   err_cnt - e0, 0);

      check("never_both", both_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
